lane_merge_buffer: RTL and testbench

Parametrised packed-lane write-merge buffer. Accepts indexed part-select writes of one or more contiguous lanes into a packed word of `LANES` × `LANE_W` bits, with either lane ordering and any signed lane base. Emits the merged word over a valid/ready handshake when every lane has been written or when a flush is requested. Sits between narrow lane-granular producers and wide packed-struct consumers in the frontend test and synthesis flows.

---
 rtl/lane_merge_pkg.sv | 19 +
 rtl/lane_run_decode.sv | 44 ++++
 rtl/lane_merge_buffer.sv | 90 +++++++++
 tb/tb_lane_merge_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_merge_pkg.sv
// Shared helpers for the lane merge buffer: lane index -> packed position mapping,
// range check, and the FILL/HOLD state type.
package lane_merge_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Packed position counted from the LSB lane of the output word.
    function automatic int lane_pos(int idx, int lanes, int lane_lo, bit ascending);
        return ascending ? (lanes - 1 - (idx - lane_lo)) : (idx - lane_lo);
    endfunction

    function automatic bit lane_in_range(int idx, int lanes, int lane_lo);
        return (idx >= lane_lo) && (idx < lane_lo + lanes);
    endfunction

endpackage

// File: rtl/lane_run_decode.sv
// Combinational decode of one lane-run write into per-position write enables and
// lane-aligned data; out-of-range lanes of the run produce no enable.
module lane_run_decode
    import lane_merge_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int LANE_W    = 8,
    parameter int LANE_LO   = 0,
    parameter int ASCENDING = 0,
    parameter int MAX_RUN   = 2,
    parameter int CNT_W     = $clog2(MAX_RUN + 1)
) (
    input  logic signed [15:0]         in_lane,
    input  logic [CNT_W-1:0]           in_count,
    input  logic [MAX_RUN*LANE_W-1:0]  in_data,
    output logic [LANES-1:0]           lane_we,
    output logic [LANES*LANE_W-1:0]    lane_data
);

    for (genvar p = 0; p < LANES; p++) begin : g_lane
        logic              we;
        logic [LANE_W-1:0] wd;

        // In ascending order the slice's LSB chunk lands on its highest index.
        always_comb begin
            int idx;
            we = 1'b0;
            wd = '0;
            for (int k = 0; k < MAX_RUN; k++) begin
                idx = (ASCENDING != 0) ? int'(in_lane) + int'(in_count) - 1 - k
                                       : int'(in_lane) + k;
                if (k < int'(in_count) && lane_in_range(idx, LANES, LANE_LO) &&
                    lane_pos(idx, LANES, LANE_LO, ASCENDING != 0) == p) begin
                    we = 1'b1;
                    wd = in_data[k*LANE_W +: LANE_W];
                end
            end
        end

        assign lane_we[p]                  = we;
        assign lane_data[p*LANE_W +: LANE_W] = wd;
    end

endmodule

// File: rtl/lane_merge_buffer.sv
// Packed-lane write-merge buffer: accumulates lane-run writes, emits the merged word
// when full or flushed. Define LANE_MERGE_STRB_EN to expose the per-lane out_strb mask.
module lane_merge_buffer
    import lane_merge_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int LANE_W    = 8,
    parameter int LANE_LO   = 0,
    parameter int ASCENDING = 0,
    parameter int MAX_RUN   = 2,
    parameter int CNT_W     = $clog2(MAX_RUN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [15:0]         in_lane,
    input  logic [CNT_W-1:0]           in_count,
    input  logic [MAX_RUN*LANE_W-1:0]  in_data,
    input  logic                       in_flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*LANE_W-1:0]    out_data
`ifdef LANE_MERGE_STRB_EN
    ,
    output logic [LANES-1:0]           out_strb
`endif
);

    state_t                  state_q, state_d;
    logic [LANES*LANE_W-1:0] data_q, data_d, run_data;
    logic [LANES-1:0]        mask_q, mask_d, run_we;
    logic                    accept;

    lane_run_decode #(
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .LANE_LO   (LANE_LO),
        .ASCENDING (ASCENDING),
        .MAX_RUN   (MAX_RUN),
        .CNT_W     (CNT_W)
    ) u_decode (
        .in_lane   (in_lane),
        .in_count  (in_count),
        .in_data   (in_data),
        .lane_we   (run_we),
        .lane_data (run_data)
    );

    assign out_valid = (state_q == S_HOLD);
    assign in_ready  = !rst && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // A write landing on the output handshake merges into an already-cleared word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (state_q == S_HOLD && out_ready) begin
            state_d = S_FILL;
            data_d  = '0;
            mask_d  = '0;
        end
        if (accept) begin
            for (int p = 0; p < LANES; p++) begin
                if (run_we[p]) data_d[p*LANE_W +: LANE_W] = run_data[p*LANE_W +: LANE_W];
            end
            mask_d = mask_d | run_we;
            if ((&mask_d) || (in_flush && (|mask_d))) state_d = S_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign out_data = data_q;
`ifdef LANE_MERGE_STRB_EN
    assign out_strb = mask_q;
`endif

endmodule

// File: tb/tb_lane_merge_buffer.sv
// Scoreboard bench: DUT0 uses defaults, DUT1 uses ASCENDING=1, LANE_LO=-10.
// The reference model holds words in arrays declared with the DUTs' own index ranges.
module tb_lane_merge_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid  [2];
    logic               in_ready  [2];
    logic signed [15:0] in_lane   [2];
    logic [1:0]         in_count  [2];
    logic [15:0]        in_data   [2];
    logic               in_flush  [2];
    logic               out_valid [2];
    logic               out_ready [2];
    logic [63:0]        out_data  [2];
`ifdef LANE_MERGE_STRB_EN
    logic [7:0]         out_strb  [2];
`endif

    lane_merge_buffer u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_lane(in_lane[0]),
        .in_count(in_count[0]), .in_data(in_data[0]), .in_flush(in_flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
`ifdef LANE_MERGE_STRB_EN
        , .out_strb(out_strb[0])
`endif
    );

    lane_merge_buffer #(.ASCENDING(1), .LANE_LO(-10)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_lane(in_lane[1]),
        .in_count(in_count[1]), .in_data(in_data[1]), .in_flush(in_flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
`ifdef LANE_MERGE_STRB_EN
        , .out_strb(out_strb[1])
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  s;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   rdy_mode [2];   // 0: always ready, 1: random, 2: never ready

    // Model words: m0 is [hi:lo] with lanes 7..0, m1 is [lo:hi] with lanes -10..-3.
    logic [7:0][7:0]    m0;
    logic [7:0]         mk0;
    logic [-10:-3][7:0] m1;
    logic [-10:-3]      mk1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        m0 = '0; mk0 = '0; m1 = '0; mk1 = '0;
    endtask

    // Part-select semantics: [hi:lo] gives the LSB chunk to the lowest index,
    // [lo:hi] gives the MSB chunk to the lowest index.
    task automatic model_write(int d, int lane, int cnt, logic [15:0] data, bit flush,
                               output bit emit, output logic [63:0] ed, output logic [7:0] es);
        for (int j = 0; j < cnt; j++) begin
            int         idx;
            logic [7:0] chunk;
            idx = lane + j;
            if (d == 0) begin
                chunk = data[j*8 +: 8];
                if (idx >= 0 && idx <= 7) begin m0[idx] = chunk; mk0[idx] = 1'b1; end
            end else begin
                chunk = data[(cnt-1-j)*8 +: 8];
                if (idx >= -10 && idx <= -3) begin m1[idx] = chunk; mk1[idx] = 1'b1; end
            end
        end
        ed = (d == 0) ? 64'(m0) : 64'(m1);
        es = (d == 0) ? mk0 : 8'(mk1);
        emit = (es == 8'hFF) || (flush && es != 8'h00);
        if (emit) begin
            if (d == 0) begin m0 = '0; mk0 = '0; end
            else begin m1 = '0; mk1 = '0; end
        end
    endtask

    task automatic do_write(int d, int lane, int cnt, logic [15:0] data, bit flush);
        bit          emit;
        logic [63:0] ed;
        logic [7:0]  es;
        int          n;
        n = 0;
        in_valid[d] = 1'b1;
        in_lane[d]  = 16'(lane);
        in_count[d] = 2'(cnt);
        in_data[d]  = data;
        in_flush[d] = flush;
        @(negedge clk);
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            tests++;
            fails++;
            $display("FAIL write_timeout dut%0d: in_ready stayed 0, expected 1", d);
            in_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_flush[d] = 1'b0;
        model_write(d, lane, cnt, data, flush, emit, ed, es);
        if (emit) begin
            if (d == 0) q0.push_back('{d: ed, s: es});
            else        q1.push_back('{d: ed, s: es});
        end
        chk($sformatf("out_valid_after_write_dut%0d", d), 64'(out_valid[d]), 64'(emit));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_valid_dut%0d", d), 64'(out_valid[d]), 64'd0);
            chk($sformatf("rst_in_ready_dut%0d", d), 64'(in_ready[d]), 64'd0);
            chk($sformatf("rst_out_data_dut%0d", d), out_data[d], 64'd0);
`ifdef LANE_MERGE_STRB_EN
            chk($sformatf("rst_out_strb_dut%0d", d), 64'(out_strb[d]), 64'd0);
`endif
        end
        model_clear();
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            out_ready[d] = (rdy_mode[d] == 0) ? 1'b1 :
                           (rdy_mode[d] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic mon(int d);
        exp_t e;
        if (out_valid[d] && out_ready[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word_dut%0d: got %h, expected no word", d, out_data[d]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("word_data_dut%0d", d), out_data[d], e.d);
`ifdef LANE_MERGE_STRB_EN
                chk($sformatf("word_strb_dut%0d", d), 64'(out_strb[d]), 64'(e.s));
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_lane[d] = 0; in_count[d] = 0;
            in_data[d] = 0; in_flush[d] = 0; out_ready[d] = 1; rdy_mode[d] = 0;
        end
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Mixed-run word, descending default layout
        do_write(0, 1, 2, 16'h1234, 0);
        do_write(0, 5, 1, 16'h0042, 0);
        do_write(0, 7, 1, 16'h00FC, 1);
        chk("plan_desc_data", out_data[0], 64'hFC00_4200_0012_3400);
`ifdef LANE_MERGE_STRB_EN
        chk("plan_desc_strb", 64'(out_strb[0]), 64'hA6);
`endif

        // Same word built through the ascending, negative-base instance
        do_write(1, -5, 2, 16'h1234, 0);
        do_write(1, -8, 1, 16'h0042, 0);
        do_write(1, -10, 1, 16'h00FC, 1);
        chk("plan_asc_neg_data", out_data[1], 64'hFC00_4200_0012_3400);

        // Run straddling the low edge, then an empty flush
        do_write(0, -1, 2, 16'hABCD, 1);
        chk("plan_drop_data", out_data[0], 64'h0000_0000_0000_00AB);
`ifdef LANE_MERGE_STRB_EN
        chk("plan_drop_strb", 64'(out_strb[0]), 64'h01);
`endif
        do_write(0, 0, 0, 16'h0000, 1);
        @(negedge clk);
        chk("empty_flush_valid", 64'(out_valid[0]), 64'd0);

        // Full word under backpressure, then a write on the handshake cycle
        rdy_mode[0] = 2;
        for (int l = 0; l < 8; l += 2) do_write(0, l, 2, 16'($urandom), 0);
        @(negedge clk);
        chk("hold_valid", 64'(out_valid[0]), 64'd1);
        chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
        rdy_mode[0] = 0;
        do_write(0, 3, 1, 16'hEE55, 0);
        do_write(0, 0, 0, 16'h0000, 1);
        chk("handshake_new_word", out_data[0], 64'h0000_0000_5500_0000);

        // Reset discards a partial word
        do_write(0, 0, 1, 16'h0011, 0);
        do_write(0, 1, 1, 16'h0022, 0);
        do_write(0, 2, 1, 16'h0033, 0);
        do_reset();
        do_write(0, 0, 0, 16'h0000, 1);
        do_write(0, 0, 1, 16'h0001, 1);
        chk("post_reset_word", out_data[0], 64'h1);

        // Randomized runs on both instances with random backpressure
        rdy_mode[0] = 1;
        rdy_mode[1] = 1;
        for (int i = 0; i < 400; i++) begin
            int d, lo;
            d  = int'($urandom_range(0, 1));
            lo = (d == 0) ? 0 : -10;
            do_write(d, lo - 2 + int'($urandom_range(0, 11)), int'($urandom_range(0, 2)),
                     16'($urandom), $urandom_range(0, 3) == 0);
        end
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
